// File: rtl/rcu_fp_pkg.sv
// rcu_fp_pkg: shared types and constants for the FP writeback path
package rcu_fp_pkg;
  localparam int FP_WRB_SRCS = 4;
  localparam int FP_REG_SIZE_WIDTH = 6;
  localparam int FP_DATA_WIDTH = 64;
  typedef enum logic [1:0] {FALU1, FALU2, LSU, FDIVSQRT} fp_wrb_src_e;
  typedef struct packed {
    logic [FP_REG_SIZE_WIDTH-1:0] addr;
    logic [FP_DATA_WIDTH-1:0] data;
  } fp_wrb_entry_t;
endpackage

// File: rtl/fp_wrb_queue.sv
// fp_wrb_queue: per-source FIFO of pending FP writebacks
module fp_wrb_queue
  import rcu_fp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fp_wrb_entry_t din,
  output logic          full,
  input  logic          pop,
  output logic          empty,
  output fp_wrb_entry_t head
);
  localparam int AW = $clog2(DEPTH);
  fp_wrb_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/fp_wrb_arbiter.sv
// fp_wrb_arbiter: queues four FP writeback sources onto two regfile write ports, round-robin
module fp_wrb_arbiter
  import rcu_fp_pkg::*;
#(
  parameter int REG_SIZE_WIDTH = FP_REG_SIZE_WIDTH,
  parameter int DATA_WIDTH = FP_DATA_WIDTH,
  parameter int QDEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0]                  src_valid_i,
  output logic [3:0]                  src_ready_o,
  input  logic [4*REG_SIZE_WIDTH-1:0] src_address_i,
  input  logic [4*DATA_WIDTH-1:0]     src_data_i,
  output logic                        wr_first_valid_o,
  output logic [REG_SIZE_WIDTH-1:0]   wr_first_address_o,
  output logic [DATA_WIDTH-1:0]       wr_first_data_o,
  output logic                        wr_second_valid_o,
  output logic [REG_SIZE_WIDTH-1:0]   wr_second_address_o,
  output logic [DATA_WIDTH-1:0]       wr_second_data_o,
  output logic                        busy_o
);
  fp_wrb_entry_t din [FP_WRB_SRCS];
  fp_wrb_entry_t heads [FP_WRB_SRCS];
  logic [3:0] full, empty, pop;
  logic [1:0] rr_ptr, first_idx, second_idx, k;
  logic first_ok, second_found, second_ok;
  for (genvar i = 0; i < FP_WRB_SRCS; i++) begin : g_q
    assign din[i] = '{addr: src_address_i[i*REG_SIZE_WIDTH +: REG_SIZE_WIDTH],
                      data: src_data_i[i*DATA_WIDTH +: DATA_WIDTH]};
    fp_wrb_queue #(.DEPTH(QDEPTH)) u_q (
      .clk(clk),
      .rst(rst),
      .push(src_valid_i[i]),
      .din(din[i]),
      .full(full[i]),
      .pop(pop[i]),
      .empty(empty[i]),
      .head(heads[i])
    );
  end
  // Scan from rr_ptr: first non-empty queue takes port 1, the next one port 2.
  always_comb begin
    first_ok = 1'b0;
    first_idx = rr_ptr;
    second_found = 1'b0;
    second_idx = rr_ptr;
    k = '0;
    for (int j = 0; j < FP_WRB_SRCS; j++) begin
      k = rr_ptr + 2'(j);
      if (!empty[k] && !first_ok) begin
        first_ok = 1'b1;
        first_idx = k;
      end else if (!empty[k] && !second_found) begin
        second_found = 1'b1;
        second_idx = k;
      end
    end
    second_ok = second_found && heads[second_idx].addr != heads[first_idx].addr;
    pop = (4'(first_ok) << first_idx) | (4'(second_ok) << second_idx);
  end
  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= '0;
    else if (first_ok) rr_ptr <= (second_ok ? second_idx : first_idx) + 2'd1;
  end
  assign src_ready_o = ~full;
  assign busy_o = |(~empty);
  assign wr_first_valid_o = first_ok;
  assign wr_first_address_o = heads[first_idx].addr;
  assign wr_first_data_o = heads[first_idx].data;
  assign wr_second_valid_o = second_ok;
  assign wr_second_address_o = heads[second_idx].addr;
  assign wr_second_data_o = heads[second_idx].data;
endmodule

// File: tb/tb_fp_wrb_arbiter.sv
// tb_fp_wrb_arbiter: directed scenarios for the FP writeback arbiter
module tb_fp_wrb_arbiter;
  logic clk, rst;
  logic [3:0] src_valid, src_ready;
  logic [23:0] src_address;
  logic [255:0] src_data;
  logic fv, sv, busy;
  logic [5:0] fa, sa;
  logic [63:0] fd, sd;
  int compared = 0;
  int mismatched = 0;

  fp_wrb_arbiter dut (
    .clk(clk),
    .rst(rst),
    .src_valid_i(src_valid),
    .src_ready_o(src_ready),
    .src_address_i(src_address),
    .src_data_i(src_data),
    .wr_first_valid_o(fv),
    .wr_first_address_o(fa),
    .wr_first_data_o(fd),
    .wr_second_valid_o(sv),
    .wr_second_address_o(sa),
    .wr_second_data_o(sd),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic set_src(input int k, input logic v, input logic [5:0] a, input logic [63:0] d);
    src_valid[k] = v;
    src_address[k*6 +: 6] = a;
    src_data[k*64 +: 64] = d;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    src_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    compared++; if (fv !== 1'b0) begin mismatched++; $display("FAIL reset_fv got %b want 0", fv); end
    compared++; if (sv !== 1'b0) begin mismatched++; $display("FAIL reset_sv got %b want 0", sv); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
    compared++; if (src_ready !== 4'b1111) begin mismatched++; $display("FAIL reset_ready got %b want 1111", src_ready); end
  endtask

  task automatic test_single;
    do_reset();
    set_src(0, 1'b1, 6'd5, 64'hA);
    @(posedge clk); #1 set_src(0, 1'b0, 6'd0, 64'h0);
    @(negedge clk);
    compared++; if (fv !== 1'b1) begin mismatched++; $display("FAIL single_fv got %b want 1", fv); end
    compared++; if (fa !== 6'd5) begin mismatched++; $display("FAIL single_fa got %0d want 5", fa); end
    compared++; if (fd !== 64'hA) begin mismatched++; $display("FAIL single_fd got %h want a", fd); end
    compared++; if (sv !== 1'b0) begin mismatched++; $display("FAIL single_sv got %b want 0", sv); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL single_busy1 got %b want 1", busy); end
    @(negedge clk);
    compared++; if (fv !== 1'b0) begin mismatched++; $display("FAIL single_fv_after got %b want 0", fv); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL single_busy0 got %b want 0", busy); end
  endtask

  task automatic test_four;
    do_reset();
    for (int k = 0; k < 4; k++) set_src(k, 1'b1, 6'(k + 1), 64'h100 + 64'(k));
    @(posedge clk); #1 src_valid = '0;
    @(negedge clk);
    compared++; if (fv !== 1'b1 || fa !== 6'd1) begin mismatched++; $display("FAIL four_c1_first got %b/%0d want 1/1", fv, fa); end
    compared++; if (fd !== 64'h100) begin mismatched++; $display("FAIL four_c1_fd got %h want 100", fd); end
    compared++; if (sv !== 1'b1 || sa !== 6'd2) begin mismatched++; $display("FAIL four_c1_second got %b/%0d want 1/2", sv, sa); end
    @(negedge clk);
    compared++; if (fv !== 1'b1 || fa !== 6'd3) begin mismatched++; $display("FAIL four_c2_first got %b/%0d want 1/3", fv, fa); end
    compared++; if (sv !== 1'b1 || sa !== 6'd4) begin mismatched++; $display("FAIL four_c2_second got %b/%0d want 1/4", sv, sa); end
    compared++; if (sd !== 64'h103) begin mismatched++; $display("FAIL four_c2_sd got %h want 103", sd); end
    @(negedge clk);
    compared++; if (busy !== 1'b0 || fv !== 1'b0) begin mismatched++; $display("FAIL four_idle got busy=%b fv=%b want 0/0", busy, fv); end
    // rr_ptr back at 0 means falu1 outranks fdivsqrt
    set_src(0, 1'b1, 6'd6, 64'h6);
    set_src(3, 1'b1, 6'd8, 64'h8);
    @(posedge clk); #1 src_valid = '0;
    @(negedge clk);
    compared++; if (fa !== 6'd6 || sa !== 6'd8 || sv !== 1'b1) begin mismatched++; $display("FAIL four_rr0 got fa=%0d sa=%0d sv=%b want 6/8/1", fa, sa, sv); end
  endtask

  task automatic test_backpressure;
    do_reset();
    set_src(0, 1'b1, 6'd10, 64'h10);
    set_src(1, 1'b1, 6'd20, 64'h20);
    set_src(2, 1'b1, 6'd30, 64'h30);
    @(posedge clk); #1;
    set_src(0, 1'b1, 6'd11, 64'h11);
    set_src(1, 1'b1, 6'd21, 64'h21);
    set_src(2, 1'b1, 6'd31, 64'h31);
    @(negedge clk);
    compared++; if (src_ready[2] !== 1'b1) begin mismatched++; $display("FAIL bp_c1_ready got %b want 1", src_ready[2]); end
    compared++; if (fa !== 6'd10 || sa !== 6'd20) begin mismatched++; $display("FAIL bp_c1_grant got %0d/%0d want 10/20", fa, sa); end
    @(posedge clk); #1;
    set_src(0, 1'b0, 6'd0, 64'h0);
    set_src(1, 1'b0, 6'd0, 64'h0);
    set_src(2, 1'b1, 6'd32, 64'h32);
    @(negedge clk);
    compared++; if (src_ready[2] !== 1'b0) begin mismatched++; $display("FAIL bp_c2_ready got %b want 0", src_ready[2]); end
    compared++; if (fa !== 6'd30 || fd !== 64'h30) begin mismatched++; $display("FAIL bp_c2_first got %0d/%h want 30/30", fa, fd); end
    compared++; if (sv !== 1'b1 || sa !== 6'd11) begin mismatched++; $display("FAIL bp_c2_second got %b/%0d want 1/11", sv, sa); end
    @(posedge clk); #1;
    @(negedge clk);
    compared++; if (src_ready[2] !== 1'b1) begin mismatched++; $display("FAIL bp_c3_ready got %b want 1", src_ready[2]); end
    compared++; if (fa !== 6'd21 || sa !== 6'd31 || sd !== 64'h31) begin mismatched++; $display("FAIL bp_c3_grant got %0d/%0d/%h want 21/31/31", fa, sa, sd); end
    @(posedge clk); #1 set_src(2, 1'b0, 6'd0, 64'h0);
    @(negedge clk);
    compared++; if (fv !== 1'b1 || fa !== 6'd32 || fd !== 64'h32) begin mismatched++; $display("FAIL bp_c4_first got %b/%0d/%h want 1/32/32", fv, fa, fd); end
    compared++; if (sv !== 1'b0) begin mismatched++; $display("FAIL bp_c4_sv got %b want 0", sv); end
    @(negedge clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL bp_drained got %b want 0", busy); end
  endtask

  task automatic test_same_addr;
    do_reset();
    set_src(1, 1'b1, 6'd9, 64'h91);
    set_src(3, 1'b1, 6'd9, 64'h93);
    @(posedge clk); #1 src_valid = '0;
    @(negedge clk);
    compared++; if (fv !== 1'b1 || fa !== 6'd9 || fd !== 64'h91) begin mismatched++; $display("FAIL same_c1_first got %b/%0d/%h want 1/9/91", fv, fa, fd); end
    compared++; if (sv !== 1'b0) begin mismatched++; $display("FAIL same_c1_sv got %b want 0", sv); end
    @(negedge clk);
    compared++; if (fv !== 1'b1 || fd !== 64'h93) begin mismatched++; $display("FAIL same_c2_first got %b/%h want 1/93", fv, fd); end
    compared++; if (sv !== 1'b0) begin mismatched++; $display("FAIL same_c2_sv got %b want 0", sv); end
    @(negedge clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL same_drained got %b want 0", busy); end
  endtask

  task automatic test_starvation;
    logic seen;
    int cyc;
    do_reset();
    seen = 1'b0;
    set_src(0, 1'b1, 6'd12, 64'h12);
    set_src(1, 1'b1, 6'd22, 64'h22);
    set_src(3, 1'b1, 6'd40, 64'h40);
    @(posedge clk); #1;
    set_src(3, 1'b0, 6'd0, 64'h0);
    set_src(0, 1'b1, 6'd13, 64'h13);
    set_src(1, 1'b1, 6'd23, 64'h23);
    @(negedge clk);
    seen = seen | (fv && fa == 6'd40) | (sv && sa == 6'd40);
    compared++; if (fa !== 6'd12 || sa !== 6'd22) begin mismatched++; $display("FAIL starve_c1 got %0d/%0d want 12/22", fa, sa); end
    @(posedge clk); #1;
    set_src(0, 1'b1, 6'd14, 64'h14);
    set_src(1, 1'b1, 6'd24, 64'h24);
    @(negedge clk);
    seen = seen | (fv && fa == 6'd40) | (sv && sa == 6'd40);
    compared++; if (fa !== 6'd40 || fd !== 64'h40) begin mismatched++; $display("FAIL starve_c2_first got %0d/%h want 40/40", fa, fd); end
    compared++; if (seen !== 1'b1) begin mismatched++; $display("FAIL starve_granted got %b want 1", seen); end
    src_valid = '0;
    cyc = 0;
    while (busy && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL starve_drain got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int k = 0; k < 4; k++) set_src(k, 1'b1, 6'(8*k + 1), 64'(8*k + 1));
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) set_src(k, 1'b1, 6'(8*k + 2), 64'(8*k + 2));
    @(negedge clk);
    compared++; if (src_ready !== 4'b1111) begin mismatched++; $display("FAIL mid_c1_ready got %b want 1111", src_ready); end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) set_src(k, 1'b1, 6'(8*k + 3), 64'(8*k + 3));
    @(negedge clk);
    compared++; if (src_ready !== 4'b0011) begin mismatched++; $display("FAIL mid_c2_ready got %b want 0011", src_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    src_valid = '0;
    @(negedge clk);
    compared++; if (src_ready !== 4'b1100 || busy !== 1'b1) begin mismatched++; $display("FAIL mid_loaded got ready=%b busy=%b want 1100/1", src_ready, busy); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL mid_busy got %b want 0", busy); end
    compared++; if (src_ready !== 4'b1111) begin mismatched++; $display("FAIL mid_ready got %b want 1111", src_ready); end
    for (int c = 0; c < 3; c++) begin
      compared++; if (fv !== 1'b0 || sv !== 1'b0) begin mismatched++; $display("FAIL mid_nowrite got %b/%b want 0/0", fv, sv); end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    src_valid = '0;
    src_address = '0;
    src_data = '0;
    test_reset();
    test_single();
    test_four();
    test_backpressure();
    test_same_addr();
    test_starvation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
